fifo_mismatch_monitor: RTL and testbench
========================================

Name: fifo_mismatch_monitor

Overview:
- Downstream consumer of the double-FIFO comparator's registered XOR bit (1 = the two FIFO outputs disagreed on that sample).
- Qualifies each comparator sample with its clock-enable and ignores the FIFO pipeline-fill window.
- Counts samples and mismatches, captures the index of the first mismatch, and trips a latched alarm on a run of consecutive mismatches.
- Results are visible on status ports for a host or a formal harness.

Parameters:
- CW, 16: width of all counters and of the first-error index.
- THRESH, 4: consecutive mismatching samples that trip the alarm; legal range 1..2^CW-1.
- ARM_DELAY, 8: qualified samples discarded after reset/clear (FIFO fill); 0 = armed immediately.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_ce  in  1  sample strobe; caller aligns it with i_mismatch (one cycle after the comparator's input enable).
- i_mismatch  in  1  comparator output bit; meaningful only when i_ce=1.
- i_clear  in  1  synchronous soft clear of all state.
- o_armed  out  1  1 while in ARMED.
- o_tripped  out  1  1 while in TRIPPED.
- o_err_sticky  out  1  set by first counted mismatch; held until reset/clear.
- o_err_count  out  CW  counted mismatches, saturating.
- o_sample_count  out  CW  counted samples, saturating.
- o_first_err  out  CW  o_sample_count value at the first counted mismatch; valid when o_err_sticky=1.
- o_run  out  CW  current consecutive-mismatch run length, saturating at THRESH.

Behaviour:
- All outputs are registered. A sample presented on cycle N is reflected on outputs at cycle N+1.
- Reset values: state = WARMUP (ARMED if ARM_DELAY=0); all counts = 0; o_first_err = 0; o_err_sticky = 0; o_armed = (ARM_DELAY==0); o_tripped = 0.
- Priority: i_reset > i_clear > i_ce.
- i_clear has the same effect as reset. A sample arriving with i_clear is discarded.
- Reset or clear mid-run aborts the run; there is no partial retention.
- State WARMUP:
  - Internal warm-up counter increments on each i_ce; i_mismatch is ignored.
  - Counters and flags stay at 0.
  - When the warm-up counter reaches ARM_DELAY-1 and i_ce=1, go to ARMED next cycle. The ARM_DELAY-th sample is still discarded.
- State ARMED, on i_ce=1:
  - o_sample_count += 1, saturating at 2^CW-1.
  - If i_mismatch=1:
    - o_err_count += 1, saturating.
    - o_run += 1, saturating at THRESH.
    - If o_err_sticky=0: o_first_err <= current o_sample_count (pre-increment value), and o_err_sticky <= 1.
  - If i_mismatch=0: o_run <= 0.
  - Trip: if the incremented run equals THRESH, go to TRIPPED at the same edge the counters update. With THRESH=1, a single mismatch trips.
- ARMED with i_ce=0: nothing changes.
- State TRIPPED: all counters, o_run and o_first_err are frozen; i_ce and i_mismatch are ignored. Exit only via reset or clear.
- Saturated counters hold at all-ones and never wrap. Saturation of o_sample_count does not stop mismatch counting or run detection.
- X on i_mismatch while i_ce=0 has no effect.

Test Plan:
- Reset, ARM_DELAY=8, 20 strobes with i_mismatch=1 on strobes 0-7 and 0 thereafter -> o_armed rises the cycle after strobe 7; o_err_count=0, o_err_sticky=0, o_sample_count=12.
- Armed, THRESH=4, mismatch pattern 0,1,1,0,1,1,1,1 on consecutive strobes:
  - o_first_err=1, o_err_count=6.
  - o_run sequence 0,1,2,0,1,2,3,4.
  - o_tripped=1 the cycle after the 8th strobe, o_sample_count=8.
- Tripped, then 10 more strobes with i_mismatch=1 -> o_err_count stays 6, o_sample_count stays 8.
- Same cycle as a tripping mismatch, assert i_clear -> next cycle WARMUP, all counts 0, o_tripped=0. Same test with i_reset and i_clear both high -> identical result.
- CW=4, ARM_DELAY=0, THRESH=15, 20 strobes alternating 1,0 -> o_sample_count saturates at 15, o_err_count=10, no trip.
- i_ce gaps: mismatches on strobes separated by idle cycles (i_ce=0) -> run continues across gaps; trip occurs on the 4th mismatching strobe, not the 4th cycle.

Source files
------------

// File: rtl/fifo_mismatch_monitor.sv
// fifo_mismatch_monitor: qualifies comparator mismatch samples, counts them and latches an alarm on a run of consecutive mismatches.
module fifo_mismatch_monitor #(
    parameter int CW = 16,
    parameter int THRESH = 4,
    parameter int ARM_DELAY = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_mismatch,
    input  logic          i_clear,
    output logic          o_armed,
    output logic          o_tripped,
    output logic          o_err_sticky,
    output logic [CW-1:0] o_err_count,
    output logic [CW-1:0] o_sample_count,
    output logic [CW-1:0] o_first_err,
    output logic [CW-1:0] o_run
);
    typedef enum logic [1:0] {WARMUP, ARMED, TRIPPED} state_t;
    localparam int WW = ARM_DELAY > 1 ? $clog2(ARM_DELAY) : 1;
    localparam logic [WW-1:0] WLAST = WW'(ARM_DELAY == 0 ? 0 : ARM_DELAY - 1);
    localparam logic [CW-1:0] MAX = '1;
    localparam logic [CW-1:0] TH = CW'(THRESH);
    localparam state_t INIT = ARM_DELAY == 0 ? ARMED : WARMUP;
    state_t state;
    logic [WW-1:0] warm;
    logic [CW-1:0] run_inc;
    // run never exceeds THRESH-1 while armed, so this cannot wrap
    always_comb run_inc = o_run + 1'b1;
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            state <= INIT;
            warm <= '0;
            o_armed <= (ARM_DELAY == 0);
            o_tripped <= 1'b0;
            o_err_sticky <= 1'b0;
            o_err_count <= '0;
            o_sample_count <= '0;
            o_first_err <= '0;
            o_run <= '0;
        end else if (i_ce) begin
            if (state == WARMUP) begin
                if (warm == WLAST) begin
                    state <= ARMED;
                    o_armed <= 1'b1;
                end else begin
                    warm <= warm + 1'b1;
                end
            end else if (state == ARMED) begin
                o_sample_count <= o_sample_count == MAX ? MAX : o_sample_count + 1'b1;
                if (i_mismatch) begin
                    o_err_count <= o_err_count == MAX ? MAX : o_err_count + 1'b1;
                    o_run <= run_inc;
                    if (!o_err_sticky) begin
                        o_first_err <= o_sample_count;
                        o_err_sticky <= 1'b1;
                    end
                    if (run_inc == TH) begin
                        state <= TRIPPED;
                        o_armed <= 1'b0;
                        o_tripped <= 1'b1;
                    end
                end else begin
                    o_run <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_mismatch_monitor.sv
// tb_fifo_mismatch_monitor: drives two monitor configurations and checks them against a cycle-level behavioural model.
module tb_fifo_mismatch_monitor;
    logic clk = 0, reset = 0, ce = 0, mismatch = 0, clear = 0;
    logic a_armed, a_tripped, a_sticky;
    logic [15:0] a_err, a_samp, a_first, a_run;
    logic b_armed, b_tripped, b_sticky;
    logic [3:0] b_err, b_samp, b_first, b_run;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    fifo_mismatch_monitor #(.CW(16), .THRESH(4), .ARM_DELAY(8)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_mismatch(mismatch), .i_clear(clear),
        .o_armed(a_armed), .o_tripped(a_tripped), .o_err_sticky(a_sticky), .o_err_count(a_err),
        .o_sample_count(a_samp), .o_first_err(a_first), .o_run(a_run));
    fifo_mismatch_monitor #(.CW(4), .THRESH(15), .ARM_DELAY(0)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_mismatch(mismatch), .i_clear(clear),
        .o_armed(b_armed), .o_tripped(b_tripped), .o_err_sticky(b_sticky), .o_err_count(b_err),
        .o_sample_count(b_samp), .o_first_err(b_first), .o_run(b_run));

    // mode: 0 warming up, 1 armed, 2 tripped
    typedef struct {int mode; int warm; int samp; int errc; int first; int sticky; int run;} mdl_t;
    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, int maxv, int th, int ad, bit rst, bit clr, bit c, bit mis);
        mdl_t n = m;
        if (rst || clr) begin
            n = '{ad == 0 ? 1 : 0, 0, 0, 0, 0, 0, 0};
            return n;
        end
        if (!c || m.mode == 2) return n;
        if (m.mode == 0) begin
            n.warm = m.warm + 1;
            if (n.warm == ad) n.mode = 1;
            return n;
        end
        n.samp = m.samp + 1 > maxv ? maxv : m.samp + 1;
        if (mis) begin
            n.errc = m.errc + 1 > maxv ? maxv : m.errc + 1;
            n.run = m.run + 1 > th ? th : m.run + 1;
            if (m.sticky == 0) begin
                n.first = m.samp;
                n.sticky = 1;
            end
            if (n.run == th) n.mode = 2;
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    logic [66:0] obs_a, exp_a;
    logic [18:0] obs_b, exp_b;
    assign obs_a = {a_armed, a_tripped, a_sticky, a_err, a_samp, a_first, a_run};
    assign obs_b = {b_armed, b_tripped, b_sticky, b_err, b_samp, b_first, b_run};
    always_comb begin
        exp_a = {ma.mode == 1, ma.mode == 2, ma.sticky == 1, 16'(ma.errc), 16'(ma.samp), 16'(ma.first), 16'(ma.run)};
        exp_b = {mb.mode == 1, mb.mode == 2, mb.sticky == 1, 4'(mb.errc), 4'(mb.samp), 4'(mb.first), 4'(mb.run)};
    end

    task automatic cyc(input bit c, input bit mis, input bit clr = 0, input bit rst = 0);
        ce = c; mismatch = mis; clear = clr; reset = rst;
        @(posedge clk);
        ma = step(ma, 65535, 4, 8, rst, clr, c, mis);
        mb = step(mb, 15, 15, 0, rst, clr, c, mis);
        #1;
    endtask

    task automatic warm_up();
        for (int i = 0; i < 8; i++) cyc(1, 1'($urandom));
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 0);
        checks++;
        if (obs_a !== 67'd0) begin errors++; $display("FAIL reset_a obs=%h exp=0", obs_a); end
        checks++;
        if (obs_b !== {1'b1, 18'd0}) begin errors++; $display("FAIL reset_b obs=%h exp=%h", obs_b, {1'b1, 18'd0}); end
    endtask

    task automatic test_warmup();
        for (int i = 0; i < 20; i++) begin
            cyc(1, i < 8);
            checks++;
            if (a_armed !== (i >= 7)) begin errors++; $display("FAIL warmup_armed strobe=%0d obs=%b exp=%b", i, a_armed, i >= 7); end
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin errors++; $display("FAIL warmup_model strobe=%0d obs=%h/%h exp=%h/%h", i, obs_a, obs_b, exp_a, exp_b); end
        end
        checks++;
        if ({a_err, a_sticky, a_samp} !== {16'd0, 1'b0, 16'd12}) begin
            errors++; $display("FAIL warmup_counts err=%0d sticky=%b samp=%0d exp 0/0/12", a_err, a_sticky, a_samp);
        end
    endtask

    task automatic test_pattern();
        logic [7:0] pat = 8'b11110110;
        int runs[8] = '{0, 1, 2, 0, 1, 2, 3, 4};
        cyc(0, 0, 1);
        warm_up();
        for (int i = 0; i < 8; i++) begin
            cyc(1, pat[i]);
            checks++;
            if (a_run !== 16'(runs[i])) begin errors++; $display("FAIL pattern_run strobe=%0d obs=%0d exp=%0d", i, a_run, runs[i]); end
            checks++;
            if (a_tripped !== (i == 7)) begin errors++; $display("FAIL pattern_trip strobe=%0d obs=%b exp=%b", i, a_tripped, i == 7); end
        end
        checks++;
        if ({a_first, a_err, a_samp} !== {16'd1, 16'd6, 16'd8}) begin
            errors++; $display("FAIL pattern_counts first=%0d err=%0d samp=%0d exp 1/6/8", a_first, a_err, a_samp);
        end
    endtask

    task automatic test_frozen();
        for (int i = 0; i < 10; i++) cyc(1, 1);
        checks++;
        if ({a_tripped, a_err, a_samp, a_run} !== {1'b1, 16'd6, 16'd8, 16'd4}) begin
            errors++; $display("FAIL frozen tripped=%b err=%0d samp=%0d run=%0d exp 1/6/8/4", a_tripped, a_err, a_samp, a_run);
        end
    endtask

    task automatic test_clear_trip(input bit with_reset);
        cyc(0, 0, 1);
        warm_up();
        for (int i = 0; i < 3; i++) cyc(1, 1);
        cyc(1, 1, 1, with_reset);
        checks++;
        if (obs_a !== 67'd0) begin errors++; $display("FAIL clear_trip rst=%b obs=%h exp=0", with_reset, obs_a); end
        checks++;
        if (obs_b !== exp_b) begin errors++; $display("FAIL clear_trip_b rst=%b obs=%h exp=%h", with_reset, obs_b, exp_b); end
    endtask

    task automatic test_saturation();
        cyc(0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(1, i % 2 == 0);
        checks++;
        if ({b_samp, b_err, b_tripped, b_armed} !== {4'd15, 4'd10, 1'b0, 1'b1}) begin
            errors++; $display("FAIL saturation samp=%0d err=%0d tripped=%b armed=%b exp 15/10/0/1", b_samp, b_err, b_tripped, b_armed);
        end
        checks++;
        if (obs_a !== exp_a) begin errors++; $display("FAIL saturation_a obs=%h exp=%h", obs_a, exp_a); end
    endtask

    task automatic test_gaps();
        cyc(0, 0, 1);
        warm_up();
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                cyc(0, 1'($urandom));
                checks++;
                if (a_tripped !== 1'b0) begin errors++; $display("FAIL gap_idle k=%0d obs=%b exp=0", k, a_tripped); end
            end
            cyc(1, 1);
            checks++;
            if (a_tripped !== (k == 3) || a_run !== 16'(k + 1)) begin
                errors++; $display("FAIL gap_strobe k=%0d tripped=%b run=%0d exp %b/%0d", k, a_tripped, a_run, k == 3, k + 1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                $urandom_range(0, 60) == 0, $urandom_range(0, 150) == 0);
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++; $display("FAIL random cyc=%0d obs=%h/%h exp=%h/%h", i, obs_a, obs_b, exp_a, exp_b);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_warmup();
        test_pattern();
        test_frozen();
        test_clear_trip(0);
        test_clear_trip(1);
        test_saturation();
        test_gaps();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
